// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states and constants shared by the multiply/divide unit.
package mdu_pkg;
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } mdu_op_t;
  typedef enum logic [1:0] {IDLE, RUN, FIX} mdu_state_t;
  localparam logic DIVZ_FILL = 1'b1;
endpackage

// File: rtl/mdu_if.sv
// mdu_if: operand/command bus and HI/LO result bus of the multiply/divide unit.
interface mdu_if #(parameter int Dbits = 32);
  logic start, hi_wr, lo_wr, busy, done;
  mdu_pkg::mdu_op_t op;
  logic [Dbits-1:0] a, b, wdata, hi, lo;
  modport master (output start, op, a, b, hi_wr, lo_wr, wdata, input busy, done, hi, lo);
  modport slave (input start, op, a, b, hi_wr, lo_wr, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_step.sv
// mdu_step: one iteration, shift-add multiply or restoring divide (divide only with MDU_DIV_EN).
module mdu_step #(parameter int Dbits = 32) (
`ifdef MDU_DIV_EN
  input  logic               div,
`endif
  input  logic [2*Dbits-1:0] acc,
  input  logic [Dbits-1:0]   m,
  output logic [2*Dbits-1:0] nxt
);
  logic [Dbits:0] sum;
`ifdef MDU_DIV_EN
  logic [Dbits:0] val;
  logic [Dbits-1:0] dif;
  logic ge;
`endif
  always_comb begin
    sum = {1'b0, acc[2*Dbits-1:Dbits]} + {1'b0, m & {Dbits{acc[0]}}};
`ifdef MDU_DIV_EN
    val = {acc[2*Dbits-1:Dbits], acc[Dbits-1]};
    ge  = val >= {1'b0, m};
    dif = val[Dbits-1:0] - m;
    nxt = div ? {ge ? dif : val[Dbits-1:0], acc[Dbits-2:0], ge} : {sum, acc[Dbits-1:1]};
`else
    nxt = {sum, acc[Dbits-1:1]};
`endif
  end
endmodule

// File: rtl/mdu.sv
// mdu: iterative 32x32 multiply / 32/32 divide with HI/LO registers.
// Divide datapath present only when MDU_DIV_EN is defined.
module mdu import mdu_pkg::*; #(parameter int Dbits = 32) (
  input logic clock,
  input logic reset,
  mdu_if.slave bus
);
  localparam int CW = $clog2(Dbits);
  mdu_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2*Dbits-1:0] acc, acc_n, prod;
  logic [Dbits-1:0] m, ma, mb, hi_q, lo_q, hi_f, lo_f;
  logic sa, sb, sa_n, sb_n, sg, isdiv, go, run, skip, pend, done_q;
`ifdef MDU_DIV_EN
  logic dv;
`endif
  mdu_step #(.Dbits(Dbits)) u_step (
`ifdef MDU_DIV_EN
    .div(dv),
`endif
    .acc(acc),
    .m(m),
    .nxt(acc_n)
  );
  always_comb begin
    sg    = bus.op == OP_MULT || bus.op == OP_DIV;
    isdiv = bus.op == OP_DIVU || bus.op == OP_DIV;
    sa_n  = sg & bus.a[Dbits-1];
    sb_n  = sg & bus.b[Dbits-1];
    ma    = sa_n ? -bus.a : bus.a;
    mb    = sb_n ? -bus.b : bus.b;
    go    = state == IDLE && bus.start;
`ifdef MDU_DIV_EN
    run   = go;
`else
    run   = go && !isdiv;
`endif
    skip  = go && !run;
    nxt   = state == IDLE ? (run ? RUN : IDLE) : state == RUN ? (cnt == '0 ? FIX : RUN) : IDLE;
    prod  = (sa ^ sb) ? -acc : acc;
    hi_f  = prod[2*Dbits-1:Dbits];
    lo_f  = prod[Dbits-1:0];
`ifdef MDU_DIV_EN
    if (dv) begin
      hi_f = sa ? -acc[2*Dbits-1:Dbits] : acc[2*Dbits-1:Dbits];
      lo_f = ~|m ? {Dbits{DIVZ_FILL}} : (sa ^ sb) ? -acc[Dbits-1:0] : acc[Dbits-1:0];
    end
`endif
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      m      <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      pend   <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
`ifdef MDU_DIV_EN
      dv     <= 1'b0;
`endif
    end else begin
      state  <= nxt;
      pend   <= skip;
      done_q <= state == FIX || pend;
      if (run) begin
        cnt <= CW'(Dbits - 1);
        acc <= {{Dbits{1'b0}}, ma};
        m   <= mb;
        sa  <= sa_n;
        sb  <= sb_n;
`ifdef MDU_DIV_EN
        dv  <= isdiv;
`endif
      end else if (state == RUN) begin
        acc <= acc_n;
        cnt <= cnt - 1'b1;
      end
      if (state == FIX) begin
        hi_q <= hi_f;
        lo_q <= lo_f;
      end else if (state == IDLE && !bus.start) begin
        if (bus.hi_wr) hi_q <= bus.wdata;
        if (bus.lo_wr) lo_q <= bus.wdata;
      end
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
